// File: rtl/ssrv_ahb_pkg.sv
// Shared AHB-lite encodings, FSM states and pipeline slot records for the ssrv AHB initiators.
package ssrv_ahb_pkg;

   localparam int AHB_DW = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_B = 3'b000;
   localparam logic [2:0] HSIZE_H = 3'b001;
   localparam logic [2:0] HSIZE_W = 3'b010;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_CANCEL = 2'd1,
      ST_HANG   = 2'd2
   } state_t;

   // Address-phase slot: everything the bus needs while htrans is NONSEQ.
   typedef struct packed {
      logic [AHB_DW-1:0] addr;
      logic              write;
      logic [2:0]        size;
      logic [AHB_DW-1:0] wdata;
   } slot_t;

   // Data-phase slot: only the fields still needed once the address has been taken.
   typedef struct packed {
      logic [1:0]        addr_lo;
      logic              write;
      logic [2:0]        size;
      logic [AHB_DW-1:0] wdata;
   } dp_t;

   function automatic logic [2:0] norm_size(input logic [2:0] size);
      return (size == HSIZE_B || size == HSIZE_H) ? size : HSIZE_W;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
      case (size)
         HSIZE_H: return addr_lo[0];
         HSIZE_W: return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ssrv_ahb_lane.sv
// Combinational AHB byte-lane helper: write-data replication and read-data extraction.
module ssrv_ahb_lane
   import ssrv_ahb_pkg::*;
(
   input  logic [2:0]        i_wsize,
   input  logic [AHB_DW-1:0] i_wdata,
   output logic [AHB_DW-1:0] o_wdata,
   input  logic [1:0]        i_raddr,
   input  logic [2:0]        i_rsize,
   input  logic [AHB_DW-1:0] i_rdata,
   output logic [AHB_DW-1:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_wsize)
         HSIZE_B: o_wdata = {4{i_wdata[7:0]}};
         HSIZE_H: o_wdata = {2{i_wdata[15:0]}};
         default: o_wdata = i_wdata;
      endcase
   end

   always_comb begin
      case (i_raddr)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_raddr[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_rsize)
         HSIZE_B: o_rdata = {24'h0, w_byte};
         HSIZE_H: o_rdata = {16'h0, w_half};
         default: o_rdata = i_rdata;
      endcase
   end

endmodule

// File: rtl/ssrv_ahb_master.sv
// AHB-lite initiator: valid/ready requests to pipelined single transfers with in-order responses.
// Optional macro SSRV_AHBM_ALIGN_CHECK_EN rejects misaligned requests without touching the bus.
module ssrv_ahb_master
   import ssrv_ahb_pkg::*;
#(
   parameter int AHB_WIDTH      = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [AHB_WIDTH-1:0] req_addr,
   input  logic                 req_write,
   input  logic [2:0]           req_size,
   input  logic [AHB_WIDTH-1:0] req_wdata,
   output logic                 rsp_valid,
   output logic [AHB_WIDTH-1:0] rsp_rdata,
   output logic                 rsp_err,
   output logic                 bus_hang,
   output logic [1:0]           htrans,
   output logic [AHB_WIDTH-1:0] haddr,
   output logic                 hwrite,
   output logic [2:0]           hsize,
   output logic [AHB_WIDTH-1:0] hwdata,
   input  logic                 hready,
   input  logic [AHB_WIDTH-1:0] hrdata,
   input  logic                 hresp
);

   localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            r_state, w_state_nx;
   logic              r_ap_vld, w_ap_vld_nx;
   slot_t             r_ap, w_ap_nx;
   logic              r_dp_vld, w_dp_vld_nx;
   dp_t               r_dp, w_dp_nx;
   logic [1:0]        r_htrans, w_htrans_nx;
   logic              r_rsp_valid, w_rsp_valid_nx;
   logic              r_rsp_err, w_rsp_err_nx;
   logic [AHB_DW-1:0] r_rsp_rdata, w_rsp_rdata_nx;
   logic [CNT_W-1:0]  r_to_cnt, w_to_cnt_nx;

   logic [2:0]        w_req_size;
   logic [AHB_DW-1:0] w_req_wrep;
   logic [AHB_DW-1:0] w_rd_ext;
   logic              w_misalign;
   logic              w_cancel, w_hang;
   logic              w_accept, w_ap_adv, w_dp_done, w_err_first, w_timeout;

   ssrv_ahb_lane u_lane (
      .i_wsize (w_req_size),
      .i_wdata (req_wdata),
      .o_wdata (w_req_wrep),
      .i_raddr (r_dp.addr_lo),
      .i_rsize (r_dp.size),
      .i_rdata (hrdata),
      .o_rdata (w_rd_ext)
   );

   assign w_req_size = norm_size(req_size);
`ifdef SSRV_AHBM_ALIGN_CHECK_EN
   assign w_misalign = is_misaligned(req_addr[1:0], w_req_size);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_cancel = (r_state == ST_CANCEL);
   assign w_hang   = (r_state == ST_HANG);

   // A misaligned request is only taken with an empty pipe so its error response stays in order.
   assign req_ready = ~w_hang & ~w_cancel & (~r_ap_vld | (hready & ~hresp))
                    & (~w_misalign | (~r_ap_vld & ~r_dp_vld));

   assign w_accept    = req_valid & req_ready;
   assign w_ap_adv    = r_ap_vld & (r_state == ST_RUN) & hready & ~hresp;
   assign w_dp_done   = r_dp_vld & hready;
   assign w_err_first = r_dp_vld & hresp & ~hready & (r_state == ST_RUN);
   assign w_timeout   = r_dp_vld & ~hready & (r_to_cnt == TO_LAST) & ~w_hang;

   // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         ST_RUN: begin
            if (w_timeout)        w_state_nx = ST_HANG;
            else if (w_err_first) w_state_nx = ST_CANCEL;
         end
         ST_CANCEL: begin
            if (w_timeout)                w_state_nx = ST_HANG;
            else if (~r_dp_vld | hready)  w_state_nx = ST_RUN;
         end
         ST_HANG:  w_state_nx = ST_HANG;
         default:  w_state_nx = ST_HANG;
      endcase
   end

   always_comb begin
      w_ap_vld_nx = r_ap_vld;
      w_ap_nx     = r_ap;
      w_dp_vld_nx = r_dp_vld;
      w_dp_nx     = r_dp;
      if (w_dp_done) w_dp_vld_nx = 1'b0;
      if (w_ap_adv) begin
         w_ap_vld_nx = 1'b0;
         w_dp_vld_nx = 1'b1;
         w_dp_nx     = '{addr_lo: r_ap.addr[1:0], write: r_ap.write,
                         size: r_ap.size, wdata: r_ap.wdata};
      end
      if (w_accept & ~w_misalign) begin
         w_ap_vld_nx = 1'b1;
         w_ap_nx     = '{addr: req_addr, write: req_write,
                         size: w_req_size, wdata: w_req_wrep};
      end
      if (w_timeout) begin
         w_ap_vld_nx = 1'b0;
         w_dp_vld_nx = 1'b0;
      end
   end

   // The bus sees IDLE whenever the next state is not RUN; a held AP returns on re-entry.
   always_comb begin
      w_htrans_nx = HTRANS_IDLE;
      if (w_state_nx == ST_RUN && w_ap_vld_nx) w_htrans_nx = HTRANS_NONSEQ;
   end

   always_comb begin
      w_rsp_valid_nx = 1'b0;
      w_rsp_err_nx   = 1'b0;
      w_rsp_rdata_nx = '0;
      if (w_timeout) begin
         w_rsp_valid_nx = 1'b1;
         w_rsp_err_nx   = 1'b1;
      end else if (w_dp_done) begin
         w_rsp_valid_nx = 1'b1;
         w_rsp_err_nx   = hresp;
         if (~r_dp.write & ~hresp) w_rsp_rdata_nx = w_rd_ext;
      end else if (w_accept & w_misalign) begin
         w_rsp_valid_nx = 1'b1;
         w_rsp_err_nx   = 1'b1;
      end
   end

   always_comb begin
      w_to_cnt_nx = r_to_cnt + 1'b1;
      if (~r_dp_vld | hready | w_timeout) w_to_cnt_nx = '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_RUN;
         r_ap_vld    <= 1'b0;
         r_ap        <= '0;
         r_dp_vld    <= 1'b0;
         r_dp        <= '0;
         r_htrans    <= HTRANS_IDLE;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_to_cnt    <= '0;
      end else begin
         r_state     <= w_state_nx;
         r_ap_vld    <= w_ap_vld_nx;
         r_ap        <= w_ap_nx;
         r_dp_vld    <= w_dp_vld_nx;
         r_dp        <= w_dp_nx;
         r_htrans    <= w_htrans_nx;
         r_rsp_valid <= w_rsp_valid_nx;
         r_rsp_err   <= w_rsp_err_nx;
         r_rsp_rdata <= w_rsp_rdata_nx;
         r_to_cnt    <= w_to_cnt_nx;
      end
   end

   assign htrans    = r_htrans;
   assign haddr     = r_ap.addr;
   assign hwrite    = r_ap.write;
   assign hsize     = r_ap.size;
   assign hwdata    = r_dp.wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign bus_hang  = w_hang;

endmodule

// File: tb/tb_ssrv_ahb_master.sv
// Directed bench for ssrv_ahb_master with a hand-driven AHB responder and TIMEOUT_CYCLES=8.
module tb_ssrv_ahb_master;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic        rsp_valid, rsp_err, bus_hang;
   logic [31:0] rsp_rdata;
   logic [1:0]  htrans;
   logic [31:0] haddr, hwdata, hrdata;
   logic        hwrite, hready, hresp;
   logic [2:0]  hsize;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ssrv_ahb_master #(.AHB_WIDTH(32), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_write (req_write),
      .req_size  (req_size),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .bus_hang  (bus_hang),
      .htrans    (htrans),
      .haddr     (haddr),
      .hwrite    (hwrite),
      .hsize     (hsize),
      .hwdata    (hwdata),
      .hready    (hready),
      .hrdata    (hrdata),
      .hresp     (hresp)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_req();
      req_valid = 1'b0;
      req_addr  = '0;
      req_write = 1'b0;
      req_size  = '0;
      req_wdata = '0;
   endtask

   task automatic drive_req(input logic [31:0] a, input logic w, input logic [2:0] sz,
                            input logic [31:0] d);
      req_valid = 1'b1;
      req_addr  = a;
      req_write = w;
      req_size  = sz;
      req_wdata = d;
   endtask

   task automatic single_write(input string tag, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] d, input logic [31:0] exp_hw);
      drive_req(a, 1'b1, sz, d);
      #1 check({tag, " ready"}, req_ready, 1);
      tick();
      check({tag, " htrans"}, htrans, 2'b10);
      check({tag, " haddr"}, haddr, a);
      idle_req();
      tick();
      check({tag, " hwdata"}, hwdata, exp_hw);
      tick();
      check({tag, " rsp_valid"}, rsp_valid, 1);
      check({tag, " rsp_err"}, rsp_err, 0);
   endtask

   task automatic single_read(input string tag, input logic [31:0] a, input logic [2:0] sz,
                              input logic [2:0] exp_hsize, input logic [31:0] hd,
                              input logic [31:0] exp);
      drive_req(a, 1'b0, sz, 32'h0);
      #1 check({tag, " ready"}, req_ready, 1);
      tick();
      check({tag, " htrans"}, htrans, 2'b10);
      check({tag, " haddr"}, haddr, a);
      check({tag, " hsize"}, hsize, exp_hsize);
      check({tag, " hwrite"}, hwrite, 0);
      idle_req();
      tick();
      hrdata = hd;
      tick();
      hrdata = '0;
      check({tag, " rsp_valid"}, rsp_valid, 1);
      check({tag, " rsp_rdata"}, rsp_rdata, exp);
      check({tag, " rsp_err"}, rsp_err, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      idle_req();
      hready = 1'b1;
      hresp  = 1'b0;
      hrdata = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst htrans", htrans, 0);
      check("rst haddr", haddr, 0);
      check("rst hsize", hsize, 0);
      check("rst hwrite", hwrite, 0);
      check("rst hwdata", hwdata, 0);
      check("rst rsp_valid", rsp_valid, 0);
      check("rst rsp_rdata", rsp_rdata, 0);
      check("rst rsp_err", rsp_err, 0);
      check("rst bus_hang", bus_hang, 0);
      rst = 1'b1;
      tick();

      // Test 1: back-to-back word writes
      drive_req(32'h100, 1'b1, 3'b010, 32'hDEADBEEF);
      #1 check("t1 ready0", req_ready, 1);
      tick();
      check("t1 htrans0", htrans, 2'b10);
      check("t1 haddr0", haddr, 32'h100);
      check("t1 hwrite0", hwrite, 1);
      check("t1 hsize0", hsize, 3'b010);
      drive_req(32'h104, 1'b1, 3'b010, 32'h12345678);
      #1 check("t1 ready1", req_ready, 1);
      tick();
      check("t1 htrans1", htrans, 2'b10);
      check("t1 haddr1", haddr, 32'h104);
      check("t1 hwdata0", hwdata, 32'hDEADBEEF);
      check("t1 rsp_valid idle", rsp_valid, 0);
      idle_req();
      tick();
      check("t1 htrans idle", htrans, 2'b00);
      check("t1 hwdata1", hwdata, 32'h12345678);
      check("t1 rsp0 valid", rsp_valid, 1);
      check("t1 rsp0 err", rsp_err, 0);
      check("t1 rsp0 rdata", rsp_rdata, 0);
      tick();
      check("t1 rsp1 valid", rsp_valid, 1);
      check("t1 rsp1 err", rsp_err, 0);
      tick();
      check("t1 rsp quiet", rsp_valid, 0);

      // Write lane replication
      single_write("wb", 32'h101, 3'b000, 32'h000000AB, 32'hABABABAB);
      single_write("wh", 32'h102, 3'b001, 32'h0000C0DE, 32'hC0DEC0DE);

      // Test 2 and read lane extraction
      single_read("t2 b203", 32'h203, 3'b000, 3'b000, 32'hA5A5A5A5, 32'h000000A5);
      single_read("rb201", 32'h201, 3'b000, 3'b000, 32'h11223344, 32'h00000033);
      single_read("rh106", 32'h106, 3'b001, 3'b001, 32'hBEEF1234, 32'h0000BEEF);
      single_read("rh104", 32'h104, 3'b001, 3'b001, 32'hBEEF1234, 32'h00001234);
      single_read("rw108", 32'h108, 3'b111, 3'b010, 32'hCAFEF00D, 32'hCAFEF00D);

      // Test 3: data-phase wait states with a queued request
      drive_req(32'h40, 1'b0, 3'b010, 32'h0);
      tick();
      check("t3 haddr0", haddr, 32'h40);
      drive_req(32'h44, 1'b0, 3'b010, 32'h0);
      #1 check("t3 ready q", req_ready, 1);
      tick();
      hready = 1'b0;
      drive_req(32'h48, 1'b0, 3'b010, 32'h0);
      #1 check("t3 ready stall", req_ready, 0);
      check("t3 haddr q", haddr, 32'h44);
      tick();
      check("t3 htrans hold", htrans, 2'b10);
      check("t3 haddr hold1", haddr, 32'h44);
      tick();
      check("t3 haddr hold2", haddr, 32'h44);
      check("t3 rsp none", rsp_valid, 0);
      hready = 1'b1;
      hrdata = 32'h00004040;
      #1 check("t3 ready release", req_ready, 1);
      tick();
      idle_req();
      hrdata = 32'h00004444;
      check("t3 rsp0 valid", rsp_valid, 1);
      check("t3 rsp0 rdata", rsp_rdata, 32'h00004040);
      check("t3 haddr 48", haddr, 32'h48);
      tick();
      hrdata = 32'h00004848;
      check("t3 rsp1 rdata", rsp_rdata, 32'h00004444);
      tick();
      hrdata = '0;
      check("t3 rsp2 valid", rsp_valid, 1);
      check("t3 rsp2 rdata", rsp_rdata, 32'h00004848);
      tick();
      check("t3 rsp quiet", rsp_valid, 0);

      // Test 4: two-cycle ERROR with a pending read
      drive_req(32'h300, 1'b1, 3'b010, 32'h33);
      tick();
      drive_req(32'h304, 1'b0, 3'b010, 32'h0);
      tick();
      idle_req();
      hresp  = 1'b1;
      hready = 1'b0;
      #1 check("t4 ready err1", req_ready, 0);
      check("t4 haddr pend", haddr, 32'h304);
      tick();
      hready = 1'b1;
      check("t4 htrans idle", htrans, 2'b00);
      check("t4 haddr held", haddr, 32'h304);
      check("t4 ready cancel", req_ready, 0);
      tick();
      hresp = 1'b0;
      check("t4 htrans reissue", htrans, 2'b10);
      check("t4 haddr reissue", haddr, 32'h304);
      check("t4 rsp err valid", rsp_valid, 1);
      check("t4 rsp err", rsp_err, 1);
      tick();
      hrdata = 32'h30403040;
      check("t4 rsp gap", rsp_valid, 0);
      tick();
      hrdata = '0;
      check("t4 rsp2 valid", rsp_valid, 1);
      check("t4 rsp2 err", rsp_err, 0);
      check("t4 rsp2 rdata", rsp_rdata, 32'h30403040);
      tick();

      // Test 5: timeout after TO stalled cycles
      drive_req(32'h500, 1'b0, 3'b010, 32'h0);
      tick();
      drive_req(32'h504, 1'b0, 3'b010, 32'h0);
      tick();
      idle_req();
      hready = 1'b0;
      for (int i = 2; i <= TO; i++) begin
         tick();
         check("t5 no rsp", rsp_valid, 0);
      end
      check("t5 no hang yet", bus_hang, 0);
      tick();
      hready = 1'b1;
      drive_req(32'h600, 1'b0, 3'b010, 32'h0);
      check("t5 rsp valid", rsp_valid, 1);
      check("t5 rsp err", rsp_err, 1);
      check("t5 hang", bus_hang, 1);
      check("t5 htrans idle", htrans, 2'b00);
      #1 check("t5 ready", req_ready, 0);
      tick();
      check("t5 ap dropped", rsp_valid, 0);
      check("t5 hang sticky", bus_hang, 1);
      check("t5 ready stuck", req_ready, 0);
      tick();
      check("t5 htrans idle2", htrans, 2'b00);
      idle_req();
      rst = 1'b0;
      #1 check("t5 hang cleared", bus_hang, 0);
      tick();
      rst = 1'b1;
      #1 check("t5 ready after rst", req_ready, 1);
      tick();

      // Test 6: misaligned half read
      drive_req(32'h101, 1'b0, 3'b001, 32'h0);
      #1 check("t6 ready", req_ready, 1);
      tick();
      idle_req();
`ifdef SSRV_AHBM_ALIGN_CHECK_EN
      check("t6 htrans idle", htrans, 2'b00);
      check("t6 rsp valid", rsp_valid, 1);
      check("t6 rsp err", rsp_err, 1);
      check("t6 rsp rdata", rsp_rdata, 0);
      tick();
      check("t6 rsp quiet", rsp_valid, 0);
      check("t6 htrans quiet", htrans, 2'b00);
`else
      check("t6 htrans", htrans, 2'b10);
      check("t6 haddr", haddr, 32'h101);
      check("t6 hsize", hsize, 3'b001);
      check("t6 rsp none", rsp_valid, 0);
      tick();
      hrdata = 32'h0000BEEF;
      tick();
      hrdata = '0;
      check("t6 rsp valid", rsp_valid, 1);
      check("t6 rsp rdata", rsp_rdata, 32'h0000BEEF);
`endif
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
